// File: rtl/mips_enc_pkg.sv
// Shared MIPS encoder/decoder constants: mnemonic codes, opcodes, funct fields, encoder states.
package mips_enc_pkg;

  typedef enum logic [3:0] {
    MN_ADD     = 4'd0,
    MN_ADDU    = 4'd1,
    MN_AND     = 4'd2,
    MN_JR      = 4'd3,
    MN_SYSCALL = 4'd4,
    MN_ADDI    = 4'd5,
    MN_ADDIU   = 4'd6,
    MN_ORI     = 4'd7,
    MN_LUI     = 4'd8,
    MN_LW      = 4'd9,
    MN_SW      = 4'd10,
    MN_BGTZ    = 4'd11,
    MN_J       = 4'd12,
    MN_JAL     = 4'd13
  } mnem_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_AND     = 6'h24;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } enc_state_e;

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Request/response bundle between an instruction producer and the encoder.
interface mips_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  mnem;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_illegal;

  modport master (
    output in_valid, mnem, rs, rt, rd, shamt, imm, target, out_ready,
    input  in_ready, out_valid, out_instr, out_illegal
  );

  modport slave (
    input  in_valid, mnem, rs, rt, rd, shamt, imm, target, out_ready,
    output in_ready, out_valid, out_instr, out_illegal
  );
endinterface

// File: rtl/mips_field_packer.sv
// Combinational packer: mnemonic + operand fields -> 32-bit MIPS word; unused fields forced to 0.
module mips_field_packer
  import mips_enc_pkg::*;
(
  input  logic [3:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] instr,
  output logic        illegal
);

  always_comb begin
    instr   = '0;
    illegal = 1'b0;
    case (mnem_e'(mnem))
      MN_ADD:     instr = {OP_RTYPE, rs, rt, rd, shamt, FN_ADD};
      MN_ADDU:    instr = {OP_RTYPE, rs, rt, rd, shamt, FN_ADDU};
      MN_AND:     instr = {OP_RTYPE, rs, rt, rd, shamt, FN_AND};
      MN_JR:      instr = {OP_RTYPE, rs, 15'b0, FN_JR};
      MN_SYSCALL: instr = {26'b0, FN_SYSCALL};
      MN_ADDI:    instr = {OP_ADDI, rs, rt, imm};
      MN_ADDIU:   instr = {OP_ADDIU, rs, rt, imm};
      MN_ORI:     instr = {OP_ORI, rs, rt, imm};
      MN_LUI:     instr = {OP_LUI, 5'b0, rt, imm};
      MN_LW:      instr = {OP_LW, rs, rt, imm};
      MN_SW:      instr = {OP_SW, rs, rt, imm};
      MN_BGTZ:    instr = {OP_BGTZ, rs, 5'b0, imm};
      MN_J:       instr = {OP_J, target};
      MN_JAL:     instr = {OP_JAL, target};
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder: 1-entry registered output stage with valid/ready, plus a
// program buffer that captures every legal word the consumer takes.
module mips_instr_encoder
  import mips_enc_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  mips_instr_encoder_if.slave bus,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [ADDR_W:0]     buf_count,
  output logic                buf_full,
  output logic                overflow,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [31:0]         rd_data
);

  enc_state_e          state;
  logic [31:0]         packed_instr;
  logic                packed_illegal;
  logic                accept;
  logic                fire;
  logic                store;
  logic [ADDR_W-1:0]   wptr;
  logic [31:0]         mem [DEPTH];

  mips_field_packer u_packer (
    .mnem    (bus.mnem),
    .rs      (bus.rs),
    .rt      (bus.rt),
    .rd      (bus.rd),
    .shamt   (bus.shamt),
    .imm     (bus.imm),
    .target  (bus.target),
    .instr   (packed_instr),
    .illegal (packed_illegal)
  );

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign fire         = bus.out_valid && bus.out_ready;
  assign buf_full     = (buf_count == (ADDR_W+1)'(DEPTH));
  // Reset gates the write so a word aborted by reset never lands in the buffer.
  assign store        = reset && fire && !bus.out_illegal && !buf_full;
  assign out_addr     = wptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= S_EMPTY;
      bus.out_valid   <= 1'b0;
      bus.out_instr   <= '0;
      bus.out_illegal <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            state           <= S_HOLD;
            bus.out_valid   <= 1'b1;
            bus.out_instr   <= packed_instr;
            bus.out_illegal <= packed_illegal;
          end
        end
        S_HOLD: begin
          if (accept) begin
            bus.out_instr   <= packed_instr;
            bus.out_illegal <= packed_illegal;
          end else if (bus.out_ready) begin
            state         <= S_EMPTY;
            bus.out_valid <= 1'b0;
          end
        end
        default: begin
          state         <= S_EMPTY;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Clear takes priority over a coincident store: the RAM write may still happen,
  // but pointer and count restart from zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr      <= '0;
      buf_count <= '0;
      overflow  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      if (clear) begin
        wptr      <= '0;
        buf_count <= '0;
        overflow  <= 1'b0;
      end else begin
        if (store) begin
          wptr      <= wptr + ADDR_W'(1);
          buf_count <= buf_count + (ADDR_W+1)'(1);
        end
        if (fire && !bus.out_illegal && buf_full)
          overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store)
      mem[wptr] <= bus.out_instr;
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: directed vectors, queue-based output monitor.
module tb_mips_instr_encoder;

  typedef struct {
    logic [31:0] instr;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [3:0]  out_addr;
  logic [4:0]  buf_count;
  logic        buf_full;
  logic        overflow;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;

  int total = 0;
  int bad   = 0;
  int m_wptr  = 0;
  int m_count = 0;
  exp_t q[$];

  mips_instr_encoder_if bus ();

  mips_instr_encoder #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .bus       (bus),
    .out_addr  (out_addr),
    .buf_count (buf_count),
    .buf_full  (buf_full),
    .overflow  (overflow),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [4:0] sh, input logic [15:0] im,
                      input logic [25:0] tg, input logic [31:0] exp_instr, input logic exp_ill);
    int n;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.mnem = m; bus.rs = s; bus.rt = t; bus.rd = d; bus.shamt = sh;
    bus.imm = im; bus.target = tg;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 64'(n), 64'd0);
        bus.in_valid = 1'b0;
        return;
      end
    end
    e.instr = exp_instr;
    e.ill   = exp_ill;
    q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Monitor: every handshake seen at the negedge fires on the following posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 64'(bus.out_instr), 64'hffffffff_ffffffff);
        end else begin
          e = q.pop_front();
          chk("out_instr", 64'(bus.out_instr), 64'(e.instr));
          chk("out_illegal", 64'(bus.out_illegal), 64'(e.ill));
          chk("out_addr", 64'(out_addr), 64'(m_wptr));
          if (!e.ill && m_count < 16) begin
            m_wptr = (m_wptr + 1) % 16;
            m_count++;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time expired, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    reset = 1'b0; clear = 1'b0; rd_addr = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.mnem = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.shamt = '0;
    bus.imm = '0; bus.target = '0;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
    chk("rst_count", 64'(buf_count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    reset = 1'b1;
    cyc();

    // Basic encodings
    send(4'd0, 5'd0, 5'd13, 5'd5, 5'd0, 16'h0, 26'h0, 32'h000d2820, 1'b0);
    cyc();
    @(negedge clk);
    chk("count_after_add", 64'(buf_count), 64'd1);
    cyc();
    send(4'd8, 5'd7, 5'd1, 5'd0, 5'd0, 16'h1001, 26'h0, 32'h3c011001, 1'b0);
    send(4'd11, 5'd9, 5'd5, 5'd0, 5'd0, 16'hfff9, 26'h0, 32'h1d20fff9, 1'b0);
    send(4'd5, 5'd13, 5'd9, 5'd0, 5'd0, 16'hfffe, 26'h0, 32'h21a9fffe, 1'b0);
    send(4'd13, 5'd3, 5'd3, 5'd3, 5'd3, 16'h1234, 26'h0100010, 32'h0c100010, 1'b0);
    send(4'd3, 5'd31, 5'd4, 5'd6, 5'd7, 16'hffff, 26'h3ffffff, 32'h03e00008, 1'b0);
    send(4'd4, 5'd31, 5'd31, 5'd31, 5'd31, 16'hffff, 26'h3ffffff, 32'h0000000c, 1'b0);
    cyc();
    @(negedge clk);
    chk("count_after_basic", 64'(buf_count), 64'd7);
    cyc();

    // Backpressure stall
    bus.out_ready = 1'b0;
    send(4'd7, 5'd1, 5'd2, 5'd0, 5'd0, 16'h00ff, 26'h0, 32'h342200ff, 1'b0);
    bus.in_valid = 1'b1;
    bus.mnem = 4'd2; bus.rs = 5'd1; bus.rt = 5'd2; bus.rd = 5'd3; bus.shamt = 5'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_out_instr", 64'(bus.out_instr), 64'h342200ff);
      chk("stall_count", 64'(buf_count), 64'd7);
      cyc();
    end
    bus.out_ready = 1'b1;
    begin
      exp_t e;
      @(negedge clk);
      chk("release_in_ready", 64'(bus.in_ready), 64'd1);
      e.instr = 32'h00221924;
      e.ill   = 1'b0;
      q.push_back(e);
    end
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("release_one_store", 64'(buf_count), 64'd8);
    cyc();
    t0 = int'($time);
    send(4'd9, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 32'h8fa80004, 1'b0);
    send(4'd10, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 32'hafa80004, 1'b0);
    send(4'd6, 5'd0, 5'd2, 5'd0, 5'd0, 16'h0001, 26'h0, 32'h24020001, 1'b0);
    chk("stream_time", 64'(int'($time) - t0), 64'd30);
    repeat (2) cyc();
    @(negedge clk);
    chk("count_after_stream", 64'(buf_count), 64'd12);
    cyc();

    // Fill, full, overflow, illegal
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    m_wptr = 0; m_count = 0;
    @(negedge clk);
    chk("clear_count", 64'(buf_count), 64'd0);
    chk("clear_addr", 64'(out_addr), 64'd0);
    cyc();
    for (int i = 0; i < 16; i++)
      send(4'd6, 5'd0, 5'd1, 5'd0, 5'd0, 16'(i), 26'h0, 32'h24010000 | 32'(i), 1'b0);
    cyc();
    @(negedge clk);
    chk("full_count", 64'(buf_count), 64'd16);
    chk("full_flag", 64'(buf_full), 64'd1);
    chk("full_no_overflow", 64'(overflow), 64'd0);
    cyc();
    send(4'd6, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0010, 26'h0, 32'h24010010, 1'b0);
    cyc();
    @(negedge clk);
    chk("overflow_set", 64'(overflow), 64'd1);
    chk("overflow_count", 64'(buf_count), 64'd16);
    cyc();
    send(4'd15, 5'd1, 5'd2, 5'd3, 5'd4, 16'hbeef, 26'h1234567, 32'h0, 1'b1);
    send(4'd14, 5'd9, 5'd9, 5'd9, 5'd9, 16'h5555, 26'h2aaaaaa, 32'h0, 1'b1);
    cyc();
    @(negedge clk);
    chk("illegal_count", 64'(buf_count), 64'd16);
    cyc();

    // Reset while a word is held
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    m_wptr = 0; m_count = 0;
    @(negedge clk);
    chk("clear_overflow", 64'(overflow), 64'd0);
    cyc();
    for (int i = 0; i < 5; i++)
      send(4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 16'h1111 + 16'(i), 26'h0, 32'h34001111 + 32'(i), 1'b0);
    cyc();
    bus.out_ready = 1'b0;
    send(4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 16'h1116, 26'h0, 32'h34001116, 1'b0);
    @(negedge clk);
    chk("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    chk("pre_reset_count", 64'(buf_count), 64'd5);
    cyc();
    reset = 1'b0;
    cyc();
    q.delete();
    m_wptr = 0; m_count = 0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_count", 64'(buf_count), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    chk("mid_rst_instr", 64'(bus.out_instr), 64'd0);
    cyc();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    rd_addr = 4'd2;
    cyc();
    @(negedge clk);
    chk("readback_2", 64'(rd_data), 64'h34001113);
    cyc();
    rd_addr = 4'd7;
    cyc();
    @(negedge clk);
    chk("readback_7", 64'(rd_data), 64'h24010007);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
